// File: rtl/line_sequencer.sv
// rtl/line_sequencer.sv - cache line to decode word sequencer; optional lookahead via LINE_SEQ_LOOKAHEAD_EN
module line_sequencer #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned IDX_W  = $clog2(WORDS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    line_valid,
    output logic                    line_ready,
    input  logic [WORD_W*WORDS-1:0] line_data,
    input  logic [IDX_W-1:0]        line_offset,
    input  logic                    flush,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [WORD_W-1:0]       word_data,
    output logic [IDX_W-1:0]        word_idx,
    output logic                    word_last,
    output logic                    busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IDX_W-1:0]          r_ptr;
    logic [IDX_W-1:0]          w_ptr_nxt;
    logic [WORD_W*WORDS-1:0]   r_line;
    logic [WORD_W*WORDS-1:0]   w_line_nxt;

    logic [WORD_W-1:0]         w_words [WORDS];
    logic                      w_word_hs;
    logic                      w_last_hs;
    logic                      w_line_acc;

`ifdef LINE_SEQ_LOOKAHEAD_EN
    logic [WORD_W*WORDS-1:0]   r_pend_line;
    logic [WORD_W*WORDS-1:0]   w_pend_line_nxt;
    logic [IDX_W-1:0]          r_pend_off;
    logic [IDX_W-1:0]          w_pend_off_nxt;
    logic                      r_pend_valid;
    logic                      w_pend_valid_nxt;
`endif

    // Split the held line into addressable words, word 0 at the LSBs.
    genvar gi;
    generate
        for (gi = 0; gi < int'(WORDS); gi++) begin : g_words
            assign w_words[gi] = r_line[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign word_valid = (r_state == S_STREAM);
    assign word_data  = w_words[r_ptr];
    assign word_idx   = r_ptr;
    assign word_last  = (r_ptr == LAST_IDX);

    assign w_word_hs  = word_valid & word_ready;
    assign w_last_hs  = w_word_hs & word_last;
    assign w_line_acc = line_valid & line_ready;

`ifdef LINE_SEQ_LOOKAHEAD_EN
    // Registered-only ready: a free pending slot, never gated by decode.
    assign line_ready = !flush & !r_pend_valid;
    assign busy       = (r_state == S_STREAM) | r_pend_valid;
`else
    // Single buffer: free when empty or when its last word leaves this cycle.
    assign line_ready = !flush & ((r_state == S_EMPTY) | w_last_hs);
    assign busy       = (r_state == S_STREAM);
`endif

    // State register and line buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_EMPTY;
            r_ptr        <= '0;
            r_line       <= '0;
`ifdef LINE_SEQ_LOOKAHEAD_EN
            r_pend_line  <= '0;
            r_pend_off   <= '0;
            r_pend_valid <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_line       <= w_line_nxt;
`ifdef LINE_SEQ_LOOKAHEAD_EN
            r_pend_line  <= w_pend_line_nxt;
            r_pend_off   <= w_pend_off_nxt;
            r_pend_valid <= w_pend_valid_nxt;
`endif
        end
    end

    // Next-state: flush wins, otherwise advance the pointer or refill the active line.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_line_nxt       = r_line;
`ifdef LINE_SEQ_LOOKAHEAD_EN
        w_pend_line_nxt  = r_pend_line;
        w_pend_off_nxt   = r_pend_off;
        w_pend_valid_nxt = r_pend_valid;
`endif
        if (flush) begin
            w_state_nxt      = S_EMPTY;
            w_ptr_nxt        = '0;
            w_line_nxt       = '0;
`ifdef LINE_SEQ_LOOKAHEAD_EN
            w_pend_valid_nxt = 1'b0;
`endif
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_line_acc) begin
                        w_state_nxt = S_STREAM;
                        w_ptr_nxt   = line_offset;
                        w_line_nxt  = line_data;
                    end
                end
                S_STREAM: begin
                    if (w_word_hs && !word_last) begin
                        w_ptr_nxt = r_ptr + IDX_W'(1);
                    end else if (w_last_hs) begin
`ifdef LINE_SEQ_LOOKAHEAD_EN
                        if (r_pend_valid) begin
                            w_ptr_nxt        = r_pend_off;
                            w_line_nxt       = r_pend_line;
                            w_pend_valid_nxt = 1'b0;
                        end else
`endif
                        if (w_line_acc) begin
                            w_ptr_nxt  = line_offset;
                            w_line_nxt = line_data;
                        end else begin
                            w_state_nxt = S_EMPTY;
                            w_ptr_nxt   = '0;
                        end
                    end
`ifdef LINE_SEQ_LOOKAHEAD_EN
                    // Active line still streaming: park the new line behind it.
                    if (w_line_acc && !w_last_hs) begin
                        w_pend_line_nxt  = line_data;
                        w_pend_off_nxt   = line_offset;
                        w_pend_valid_nxt = 1'b1;
                    end
`endif
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_ptr_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_sequencer.sv
// tb/tb_line_sequencer.sv - directed self-checking bench for line_sequencer
module tb_line_sequencer;

    localparam int WORD_W = 16;
    localparam int WORDS  = 4;
    localparam int IDX_W  = 2;

    localparam logic [63:0] L0 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] L1 = 64'h8888_7777_6666_5555;

    logic                    clk;
    logic                    rst_n;
    logic                    line_valid;
    logic                    line_ready;
    logic [WORD_W*WORDS-1:0] line_data;
    logic [IDX_W-1:0]        line_offset;
    logic                    flush;
    logic                    word_valid;
    logic                    word_ready;
    logic [WORD_W-1:0]       word_data;
    logic [IDX_W-1:0]        word_idx;
    logic                    word_last;
    logic                    busy;

    int n_checks;
    int n_errors;

    line_sequencer #(.WORD_W(WORD_W), .WORDS(WORDS), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_valid  (line_valid),
        .line_ready  (line_ready),
        .line_data   (line_data),
        .line_offset (line_offset),
        .flush       (flush),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .word_idx    (word_idx),
        .word_last   (word_last),
        .busy        (busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before checking.
    task automatic set_in(input logic lv, input logic [63:0] ld, input logic [1:0] lo,
                          input logic fl, input logic wr);
        @(negedge clk);
        line_valid  = lv;
        line_data   = ld;
        line_offset = lo;
        flush       = fl;
        word_ready  = wr;
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [15:0] d,
                               input logic [1:0] i, input logic l);
        chk({tag, ".valid"}, 64'(word_valid), 64'(1'b1));
        chk({tag, ".data"},  64'(word_data),  64'(d));
        chk({tag, ".idx"},   64'(word_idx),   64'(i));
        chk({tag, ".last"},  64'(word_last),  64'(l));
        chk({tag, ".busy"},  64'(busy),       64'(1'b1));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, ".valid"}, 64'(word_valid), 64'(1'b0));
        chk({tag, ".busy"},  64'(busy),       64'(1'b0));
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, ".valid"}, 64'(word_valid), 64'(1'b0));
        chk({tag, ".data"},  64'(word_data),  64'(16'h0));
        chk({tag, ".idx"},   64'(word_idx),   64'(2'd0));
        chk({tag, ".last"},  64'(word_last),  64'(1'b0));
        chk({tag, ".busy"},  64'(busy),       64'(1'b0));
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        line_valid  = 1'b0;
        line_data   = '0;
        line_offset = '0;
        flush       = 1'b0;
        word_ready  = 1'b0;

        // reset values
        @(negedge clk);
        #1;
        expect_reset("rst");
        rst_n = 1'b1;

        // full line from offset 0
        set_in(1'b1, L0, 2'd0, 1'b0, 1'b1);
        chk("t1.line_ready", 64'(line_ready), 64'(1'b1));
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t1.w0", 16'h1111, 2'd0, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t1.w1", 16'h2222, 2'd1, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t1.w2", 16'h3333, 2'd2, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t1.w3", 16'h4444, 2'd3, 1'b1);
        chk("t1.ready_at_last", 64'(line_ready), 64'(1'b1));
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_idle("t1.end");

        // offset 2, then offset 3
        set_in(1'b1, L0, 2'd2, 1'b0, 1'b1);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t2.w2", 16'h3333, 2'd2, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t2.w3", 16'h4444, 2'd3, 1'b1);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_idle("t2.end");
        set_in(1'b1, L0, 2'd3, 1'b0, 1'b1);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t2b.w3", 16'h4444, 2'd3, 1'b1);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_idle("t2b.end");

        // stalls hold the outputs
        set_in(1'b1, L0, 2'd0, 1'b0, 1'b1);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t3.c1", 16'h1111, 2'd0, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b0); expect_word("t3.c2", 16'h2222, 2'd1, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b0); expect_word("t3.c3", 16'h2222, 2'd1, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t3.c4", 16'h2222, 2'd1, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b0); expect_word("t3.c5", 16'h3333, 2'd2, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t3.c6", 16'h3333, 2'd2, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t3.c7", 16'h4444, 2'd3, 1'b1);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_idle("t3.end");

        // back-to-back lines, no bubble
        set_in(1'b1, L0, 2'd0, 1'b0, 1'b1);
        chk("t4.ready0", 64'(line_ready), 64'(1'b1));
`ifdef LINE_SEQ_LOOKAHEAD_EN
        set_in(1'b1, L1, 2'd0, 1'b0, 1'b1); expect_word("t4.a0", 16'h1111, 2'd0, 1'b0);
        chk("t4.ready_early", 64'(line_ready), 64'(1'b1));
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b0); expect_word("t4.a1", 16'h2222, 2'd1, 1'b0);
        chk("t4.ready_pend_stall", 64'(line_ready), 64'(1'b0));
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t4.a1b", 16'h2222, 2'd1, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t4.a2", 16'h3333, 2'd2, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t4.a3", 16'h4444, 2'd3, 1'b1);
        chk("t4.ready_pend_last", 64'(line_ready), 64'(1'b0));
`else
        set_in(1'b1, L1, 2'd0, 1'b0, 1'b1); expect_word("t4.a0", 16'h1111, 2'd0, 1'b0);
        chk("t4.ready_mid0", 64'(line_ready), 64'(1'b0));
        set_in(1'b1, L1, 2'd0, 1'b0, 1'b1); expect_word("t4.a1", 16'h2222, 2'd1, 1'b0);
        set_in(1'b1, L1, 2'd0, 1'b0, 1'b1); expect_word("t4.a2", 16'h3333, 2'd2, 1'b0);
        chk("t4.ready_mid2", 64'(line_ready), 64'(1'b0));
        set_in(1'b1, L1, 2'd0, 1'b0, 1'b1); expect_word("t4.a3", 16'h4444, 2'd3, 1'b1);
        chk("t4.ready_last", 64'(line_ready), 64'(1'b1));
`endif
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t4.b0", 16'h5555, 2'd0, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t4.b1", 16'h6666, 2'd1, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t4.b2", 16'h7777, 2'd2, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t4.b3", 16'h8888, 2'd3, 1'b1);
        chk("t4.ready_end", 64'(line_ready), 64'(1'b1));
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_idle("t4.end");

        // flush at idx 1 with a line offered in the same cycle
        set_in(1'b1, L0, 2'd0, 1'b0, 1'b1);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t5.w0", 16'h1111, 2'd0, 1'b0);
        set_in(1'b1, L1, 2'd1, 1'b1, 1'b1); expect_word("t5.w1", 16'h2222, 2'd1, 1'b0);
        chk("t5.ready_flush", 64'(line_ready), 64'(1'b0));
        set_in(1'b1, L1, 2'd1, 1'b0, 1'b1); expect_idle("t5.after");
        chk("t5.ready_after", 64'(line_ready), 64'(1'b1));
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t5.r1", 16'h6666, 2'd1, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t5.r2", 16'h7777, 2'd2, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t5.r3", 16'h8888, 2'd3, 1'b1);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_idle("t5.end");

        // asynchronous reset mid-line
        set_in(1'b1, L0, 2'd0, 1'b0, 1'b1);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t6.w0", 16'h1111, 2'd0, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t6.w1", 16'h2222, 2'd1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        expect_reset("t6.rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        set_in(1'b1, L1, 2'd2, 1'b0, 1'b1);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t6.r2", 16'h7777, 2'd2, 1'b0);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_word("t6.r3", 16'h8888, 2'd3, 1'b1);
        set_in(1'b0, 64'h0, 2'd0, 1'b0, 1'b1); expect_idle("t6.end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
